// File: rtl/pmod_enc_decoder.sv
// Pmod ENC front end: 2-flop sync, per-pin debounce, quadrature decode and bounded position count.
// Define PMOD_ENC_WRAP_EN to wrap the count at its bounds instead of saturating.
module pmod_enc_decoder #(
    parameter int DEBOUNCE_CYCLES = 100_000,
    parameter int MAX_COUNT       = 19
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enc_a,
    input  logic       enc_b,
    input  logic       enc_btn,
    output logic [4:0] enc,
    output logic       step,
    output logic       dir,
    output logic       btn_db
);

    localparam int               CNT_W       = 20;
    localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [4:0]       MAX_C       = 5'(MAX_COUNT);
    localparam logic [2:0]       IDLE_LEVELS = 3'b011;

    typedef enum logic [2:0] {
        IDLE,
        CW1,
        CW2,
        CW3,
        CCW1,
        CCW2,
        CCW3
    } state_t;

    // Bit order for the pin vectors is {btn, b, a}.
    logic [2:0]            sync1_q, sync2_q;
    logic [2:0]            stable_q, stable_d;
    logic [2:0][CNT_W-1:0] cnt_q, cnt_d;
    state_t                state_q, state_d;
    logic                  lost_q, lost_d;
    logic                  cwEvt_q, cwEvt_d;
    logic                  ccwEvt_q, ccwEvt_d;
    logic                  btnPrev_q;
    logic [4:0]            enc_q, enc_d;
    logic                  step_q, step_d;
    logic                  dir_q, dir_d;
    logic [1:0]            ab;
    logic [1:0]            stateCode;
    logic                  btnRise;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= IDLE_LEVELS;
            sync2_q  <= IDLE_LEVELS;
            stable_q <= IDLE_LEVELS;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= {enc_btn, enc_b, enc_a};
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    stable_d[i] = ~stable_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign ab      = {stable_q[0], stable_q[1]};
    assign btnRise = stable_q[2] & ~btnPrev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            lost_q    <= 1'b0;
            cwEvt_q   <= 1'b0;
            ccwEvt_q  <= 1'b0;
            btnPrev_q <= 1'b0;
            enc_q     <= '0;
            step_q    <= 1'b0;
            dir_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            lost_q    <= lost_d;
            cwEvt_q   <= cwEvt_d;
            ccwEvt_q  <= ccwEvt_d;
            btnPrev_q <= stable_q[2];
            enc_q     <= enc_d;
            step_q    <= step_d;
            dir_q     <= dir_d;
        end
    end

    always_comb begin
        stateCode = 2'b11;
        case (state_q)
            CW1, CCW3: stateCode = 2'b01;
            CW2, CCW2: stateCode = 2'b00;
            CW3, CCW1: stateCode = 2'b10;
            default:   stateCode = 2'b11;
        endcase
    end

    // A double-bit jump parks the FSM (lost) until the detent code is seen again.
    always_comb begin
        state_d  = state_q;
        lost_d   = lost_q;
        cwEvt_d  = 1'b0;
        ccwEvt_d = 1'b0;
        if (lost_q) begin
            if (ab == 2'b11) begin
                state_d = IDLE;
                lost_d  = 1'b0;
            end
        end else if ((ab ^ stateCode) == 2'b11) begin
            if (ab == 2'b11) begin
                state_d = IDLE;
            end else begin
                lost_d = 1'b1;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (ab == 2'b01) state_d = CW1;
                    else if (ab == 2'b10) state_d = CCW1;
                end
                CW1: begin
                    if (ab == 2'b00) state_d = CW2;
                    else if (ab == 2'b11) state_d = IDLE;
                end
                CW2: begin
                    if (ab == 2'b10) state_d = CW3;
                    else if (ab == 2'b01) state_d = CW1;
                end
                CW3: begin
                    if (ab == 2'b11) begin
                        state_d = IDLE;
                        cwEvt_d = 1'b1;
                    end else if (ab == 2'b00) begin
                        state_d = CW2;
                    end
                end
                CCW1: begin
                    if (ab == 2'b00) state_d = CCW2;
                    else if (ab == 2'b11) state_d = IDLE;
                end
                CCW2: begin
                    if (ab == 2'b01) state_d = CCW3;
                    else if (ab == 2'b10) state_d = CCW1;
                end
                CCW3: begin
                    if (ab == 2'b11) begin
                        state_d  = IDLE;
                        ccwEvt_d = 1'b1;
                    end else if (ab == 2'b00) begin
                        state_d = CCW2;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // A button edge overrides a step arriving in the same cycle.
    always_comb begin
        enc_d  = enc_q;
        step_d = 1'b0;
        dir_d  = dir_q;
        if (btnRise) begin
            enc_d = '0;
        end else if (cwEvt_q) begin
            dir_d = 1'b1;
            if (enc_q < MAX_C) begin
                enc_d  = enc_q + 5'd1;
                step_d = 1'b1;
            end
`ifdef PMOD_ENC_WRAP_EN
            else begin
                enc_d  = '0;
                step_d = 1'b1;
            end
`endif
        end else if (ccwEvt_q) begin
            dir_d = 1'b0;
            if (enc_q != 5'd0) begin
                enc_d  = enc_q - 5'd1;
                step_d = 1'b1;
            end
`ifdef PMOD_ENC_WRAP_EN
            else begin
                enc_d  = MAX_C;
                step_d = 1'b1;
            end
`endif
        end
    end

    assign enc    = enc_q;
    assign step   = step_q;
    assign dir    = dir_q;
    assign btn_db = stable_q[2];

endmodule

// File: tb/tb_pmod_enc_decoder.sv
// Self-checking bench for pmod_enc_decoder: directed vector table, corner sequences and
// randomized code streams checked against a displacement-based reference model.
module tb_pmod_enc_decoder;

    localparam int DB   = 4;
    localparam int MAXC = 19;
`ifdef PMOD_ENC_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       enc_a, enc_b, enc_btn;
    logic [4:0] enc;
    logic       step, dir, btn_db;

    int checks = 0;
    int failures = 0;
    int stepCount = 0;
    int stepNoChange = 0;
    int maxEncSeen = 0;
    logic [4:0] prevEnc = '0;

    int mEnc, mDir, mSteps, mD;
    bit mLost;
    logic [1:0] cur;

    typedef struct {
        string           name;
        logic [4:0][1:0] codes;
        int              expEnc;
        int              expDir;
        int              expSteps;
    } vec_t;

    vec_t vecs[8];

    pmod_enc_decoder #(.DEBOUNCE_CYCLES(DB), .MAX_COUNT(MAXC)) dut (
        .clk     (clk),
        .rst     (rst),
        .enc_a   (enc_a),
        .enc_b   (enc_b),
        .enc_btn (enc_btn),
        .enc     (enc),
        .step    (step),
        .dir     (dir),
        .btn_db  (btn_db)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (step) begin
            stepCount++;
            if (enc == prevEnc) stepNoChange++;
        end
        if (int'(enc) > maxEncSeen) maxEncSeen = int'(enc);
        prevEnc = enc;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] code, input int hold);
        enc_a = code[1];
        enc_b = code[0];
        repeat (hold) @(negedge clk);
    endtask

    task automatic cwDetent(input int hold);
        applyStimulus(2'b01, hold);
        applyStimulus(2'b00, hold);
        applyStimulus(2'b10, hold);
        applyStimulus(2'b11, 10);
    endtask

    task automatic ccwDetent(input int hold);
        applyStimulus(2'b10, hold);
        applyStimulus(2'b00, hold);
        applyStimulus(2'b01, hold);
        applyStimulus(2'b11, 10);
    endtask

    task automatic doReset();
        rst = 1'b1;
        enc_a = 1'b1;
        enc_b = 1'b1;
        enc_btn = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    function automatic int idxOf(input logic [1:0] c);
        case (c)
            2'b11:   return 0;
            2'b01:   return 1;
            2'b00:   return 2;
            default: return 3;
        endcase
    endfunction

    task automatic modelStep(input bit cw);
        mDir = cw ? 1 : 0;
        if (cw) begin
            if (mEnc < MAXC) begin
                mEnc++;
                mSteps++;
            end else if (WRAP) begin
                mEnc = 0;
                mSteps++;
            end
        end else begin
            if (mEnc > 0) begin
                mEnc--;
                mSteps++;
            end else if (WRAP) begin
                mEnc = MAXC;
                mSteps++;
            end
        end
    endtask

    // Displacement along the CW cycle: a full detent is +4 or -4 when 11 is reached again.
    task automatic modelCode(input logic [1:0] nxt);
        int delta;
        if (nxt == cur) return;
        delta = (idxOf(nxt) - idxOf(cur) + 4) % 4;
        if (mLost) begin
            if (nxt == 2'b11) begin
                mLost = 1'b0;
                mD = 0;
            end
        end else if (delta == 2) begin
            if (nxt == 2'b11) mD = 0;
            else mLost = 1'b1;
        end else begin
            mD += (delta == 1) ? 1 : -1;
            if (nxt == 2'b11) begin
                if (mD == 4) modelStep(1'b1);
                else if (mD == -4) modelStep(1'b0);
                mD = 0;
            end
        end
        cur = nxt;
    endtask

    initial begin
        int s0;
        int e0;
        int r;
        logic [1:0] nxt;

        vecs[0] = '{name:"cw_full",         codes:{2'b11,2'b01,2'b00,2'b10,2'b11}, expEnc:1,              expDir:1, expSteps:1};
        vecs[1] = '{name:"partial_rev",     codes:{2'b11,2'b01,2'b00,2'b01,2'b11}, expEnc:1,              expDir:1, expSteps:0};
        vecs[2] = '{name:"ccw_full",        codes:{2'b11,2'b10,2'b00,2'b01,2'b11}, expEnc:0,              expDir:0, expSteps:1};
        vecs[3] = '{name:"ccw_at_zero",     codes:{2'b11,2'b10,2'b00,2'b01,2'b11}, expEnc:(WRAP ? MAXC : 0), expDir:0, expSteps:(WRAP ? 1 : 0)};
        vecs[4] = '{name:"cw_after_bound",  codes:{2'b11,2'b01,2'b00,2'b10,2'b11}, expEnc:(WRAP ? 0 : 1),  expDir:1, expSteps:1};
        vecs[5] = '{name:"illegal_jump",    codes:{2'b11,2'b01,2'b10,2'b00,2'b11}, expEnc:(WRAP ? 0 : 1),  expDir:1, expSteps:0};
        vecs[6] = '{name:"cw_partial_back", codes:{2'b11,2'b01,2'b11,2'b11,2'b11}, expEnc:(WRAP ? 0 : 1),  expDir:1, expSteps:0};
        vecs[7] = '{name:"ccw_partial",     codes:{2'b11,2'b10,2'b00,2'b10,2'b11}, expEnc:(WRAP ? 0 : 1),  expDir:1, expSteps:0};

        rst = 1'b1;
        enc_a = 1'b1;
        enc_b = 1'b1;
        enc_btn = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_enc", enc, 0);
        checkOutput("reset_step", step, 0);
        checkOutput("reset_dir", dir, 0);
        checkOutput("reset_btn_db", btn_db, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            s0 = stepCount;
            for (int j = 4; j >= 0; j--) applyStimulus(vecs[i].codes[j], 10);
            repeat (4) @(negedge clk);
            checkOutput({vecs[i].name, "_enc"}, enc, vecs[i].expEnc);
            checkOutput({vecs[i].name, "_dir"}, dir, vecs[i].expDir);
            checkOutput({vecs[i].name, "_steps"}, stepCount - s0, vecs[i].expSteps);
        end

        // Glitches shorter than the debounce window must be invisible.
        e0 = vecs[7].expEnc;
        s0 = stepCount;
        enc_a = 1'b0;
        repeat (DB - 1) @(negedge clk);
        enc_a = 1'b1;
        repeat (15) @(negedge clk);
        enc_b = 1'b0;
        repeat (DB - 1) @(negedge clk);
        enc_b = 1'b1;
        repeat (15) @(negedge clk);
        checkOutput("glitch_enc", enc, e0);
        checkOutput("glitch_steps", stepCount - s0, 0);
        cwDetent(10);
        checkOutput("glitch_then_cw_enc", enc, e0 + 1);

        // Bound behaviour over 21 CW detents.
        doReset();
        s0 = stepCount;
        for (int k = 1; k <= 21; k++) begin
            cwDetent(6);
            checkOutput($sformatf("sat_enc_%0d", k), enc, WRAP ? (k % (MAXC + 1)) : ((k < MAXC) ? k : MAXC));
        end
        checkOutput("sat_steps", stepCount - s0, WRAP ? 21 : MAXC);
        checkOutput("sat_dir", dir, 1);

        // Button edge lands in the same cycle as a completed CW detent.
        doReset();
        for (int k = 0; k < 6; k++) cwDetent(10);
        ccwDetent(10);
        checkOutput("pre_btn_enc", enc, 5);
        checkOutput("pre_btn_dir", dir, 0);
        s0 = stepCount;
        applyStimulus(2'b01, 10);
        applyStimulus(2'b00, 10);
        applyStimulus(2'b10, 10);
        applyStimulus(2'b11, 1);
        enc_btn = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("btn_edge_enc_before", enc, 5);
        checkOutput("btn_edge_btn_db", btn_db, 1);
        @(negedge clk);
        checkOutput("btn_clear_enc", enc, 0);
        checkOutput("btn_clear_step", step, 0);
        repeat (3) @(negedge clk);
        enc_btn = 1'b0;
        repeat (12) @(negedge clk);
        checkOutput("btn_final_enc", enc, 0);
        checkOutput("btn_final_dir", dir, 0);
        checkOutput("btn_steps", stepCount - s0, 0);
        checkOutput("btn_release_db", btn_db, 0);

        // Reset mid-rotation, then CCW at zero.
        doReset();
        for (int k = 0; k < 7; k++) cwDetent(10);
        checkOutput("pre_rst_enc", enc, 7);
        checkOutput("pre_rst_dir", dir, 1);
        applyStimulus(2'b01, 10);
        applyStimulus(2'b00, 10);
        rst = 1'b1;
        enc_a = 1'b1;
        enc_b = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_enc", enc, 0);
        checkOutput("mid_rst_step", step, 0);
        checkOutput("mid_rst_dir", dir, 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        s0 = stepCount;
        ccwDetent(10);
        checkOutput("post_rst_ccw_enc", enc, WRAP ? MAXC : 0);
        checkOutput("post_rst_ccw_dir", dir, 0);
        checkOutput("post_rst_ccw_steps", stepCount - s0, WRAP ? 1 : 0);

        // Randomized code streams against the reference model.
        doReset();
        mEnc = 0;
        mDir = 0;
        mD = 0;
        mLost = 1'b0;
        cur = 2'b11;
        for (int t = 0; t < 6; t++) begin
            mSteps = 0;
            s0 = stepCount;
            for (int n = 0; n < 40; n++) begin
                r = int'($urandom_range(0, 99));
                if (r < 8 && cur == 2'b11) begin
                    enc_btn = 1'b1;
                    repeat (8) @(negedge clk);
                    enc_btn = 1'b0;
                    repeat (8) @(negedge clk);
                    mEnc = 0;
                end else if (r < 14) begin
                    if ($urandom_range(0, 1) == 1) enc_a = ~enc_a;
                    else enc_b = ~enc_b;
                    repeat (int'($urandom_range(1, DB - 1))) @(negedge clk);
                    applyStimulus(cur, 5);
                end else begin
                    if (r < 20) nxt = cur ^ 2'b11;
                    else if ($urandom_range(0, 1) == 1) nxt = cur ^ 2'b10;
                    else nxt = cur ^ 2'b01;
                    applyStimulus(nxt, int'($urandom_range(5, 12)));
                    modelCode(nxt);
                end
            end
            repeat (10) @(negedge clk);
            checkOutput($sformatf("rand%0d_enc", t), enc, mEnc);
            checkOutput($sformatf("rand%0d_dir", t), dir, mDir);
            checkOutput($sformatf("rand%0d_steps", t), stepCount - s0, mSteps);
        end

        checkOutput("step_without_change", stepNoChange, 0);
        checkOutput("enc_above_max", (maxEncSeen > MAXC) ? 1 : 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
